lc3b_mem_ctrl: RTL and testbench

//  Requester/initiator for the split byte-wide memory banks (low byte / high byte, 256 x 8 each).

---
 rtl/lc3b_mem_pkg.sv | 17 +
 rtl/lc3b_byte_lane.sv | 47 ++++
 rtl/lc3b_mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_lc3b_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_pkg.sv
// Shared definitions for the LC-3b split byte-bank memory path:
// controller state encodings, access-size codes and bank geometry.
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    localparam logic SIZE_WORD   = 1'b0;
    localparam logic SIZE_BYTE   = 1'b1;

    localparam int   BANK_ADDR_W = 8;
    localparam int   CNT_W       = 4;

endpackage

// File: rtl/lc3b_byte_lane.sv
// Combinational byte-lane steering: per-bank write enables and write data,
// plus read-data select/zero-extension, from access size and address bit 0.
module lc3b_byte_lane
    import lc3b_mem_pkg::*;
(
    input  logic        size,
    input  logic        lane_sel,
    input  logic        suppress,
    input  logic [15:0] wdata,
    input  logic [7:0]  lo_rdata,
    input  logic [7:0]  hi_rdata,
    output logic        lo_wen,
    output logic        hi_wen,
    output logic [7:0]  lo_wdata,
    output logic [7:0]  hi_wdata,
    output logic [15:0] rd_data
);

    // Lane enables and data steering for the current access
    always_comb begin
        lo_wen   = 1'b0;
        hi_wen   = 1'b0;
        lo_wdata = wdata[7:0];
        hi_wdata = wdata[15:8];
        rd_data  = 16'h0000;
        if (suppress) begin
            lo_wen  = 1'b0;
            hi_wen  = 1'b0;
            rd_data = 16'h0000;
        end else if (size == SIZE_WORD) begin
            lo_wen  = 1'b1;
            hi_wen  = 1'b1;
            rd_data = {hi_rdata, lo_rdata};
        end else begin
            // A byte store presents the same byte to both banks; only one is enabled
            hi_wdata = wdata[7:0];
            lo_wen   = ~lane_sel;
            hi_wen   = lane_sel;
            if (lane_sel == SIZE_BYTE) begin
                rd_data = {8'h00, hi_rdata};
            end else begin
                rd_data = {8'h00, lo_rdata};
            end
        end
    end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory controller: sequences one word/byte access over MEM_CYCLES
// clocks against split lo/hi byte banks. Optional MEMCTRL_ALIGN_ERR_EN flags misaligned words.
module lc3b_mem_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int MEM_CYCLES = 4,
    parameter int ADDR_W     = BANK_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              mem_ready,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] lo_addr,
    output logic [7:0]        lo_wdata,
    output logic              lo_we_n,
    input  logic [7:0]        lo_rdata,
    output logic [ADDR_W-1:0] hi_addr,
    output logic [7:0]        hi_wdata,
    output logic              hi_we_n,
    input  logic [7:0]        hi_rdata
`ifdef MEMCTRL_ALIGN_ERR_EN
    ,
    output logic              align_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              we_q,        we_d;
    logic              size_q,      size_d;
    logic              lane_q,      lane_d;
    logic              misalign_q,  misalign_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [15:0]       wdata_q,     wdata_d;
    logic [15:0]       rdata_q,     rdata_d;
    logic              ready_q,     ready_d;
    logic              busy_q,      busy_d;
    logic              lo_we_n_q,   lo_we_n_d;
    logic              hi_we_n_q,   hi_we_n_d;
    logic [7:0]        lo_wdata_q;
    logic [7:0]        hi_wdata_q;

    logic              lo_wen_s;
    logic              hi_wen_s;
    logic [7:0]        lo_wdata_s;
    logic [7:0]        hi_wdata_s;
    logic [15:0]       lane_rdata_s;
    logic              unused_addr_s;

    // Address bits above the bank word address simply wrap
    assign unused_addr_s = ^req_addr[15:ADDR_W+1];

    lc3b_byte_lane u_lane (
        .size     (size_q),
        .lane_sel (lane_q),
        .suppress (misalign_q),
        .wdata    (wdata_q),
        .lo_rdata (lo_rdata),
        .hi_rdata (hi_rdata),
        .lo_wen   (lo_wen_s),
        .hi_wen   (hi_wen_s),
        .lo_wdata (lo_wdata_s),
        .hi_wdata (hi_wdata_s),
        .rd_data  (lane_rdata_s)
    );

    // Next-state, request latch, bank strobe and completion logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        lane_d     = lane_q;
        misalign_d = misalign_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        lo_we_n_d  = 1'b1;
        hi_we_n_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    we_d    = req_we;
                    size_d  = req_byte;
                    lane_d  = req_addr[0];
                    addr_d  = req_addr[ADDR_W:1];
                    wdata_d = req_wdata;
`ifdef MEMCTRL_ALIGN_ERR_EN
                    misalign_d = (req_byte == SIZE_WORD) && req_addr[0];
`else
                    misalign_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                    rdata_d = lane_rdata_s;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    // Strobe lands in the final ACCESS cycle: one bank negedge write
                    if (cnt_q == CNT_ONE) begin
                        lo_we_n_d = ~(we_q & lo_wen_s);
                        hi_we_n_d = ~(we_q & hi_wen_s);
                    end else begin
                        lo_we_n_d = 1'b1;
                        hi_we_n_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            we_q       <= 1'b0;
            size_q     <= SIZE_WORD;
            lane_q     <= 1'b0;
            misalign_q <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            lo_we_n_q  <= 1'b1;
            hi_we_n_q  <= 1'b1;
            lo_wdata_q <= 8'h00;
            hi_wdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            lane_q     <= lane_d;
            misalign_q <= misalign_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            lo_we_n_q  <= lo_we_n_d;
            hi_we_n_q  <= hi_we_n_d;
            lo_wdata_q <= lo_wdata_s;
            hi_wdata_q <= hi_wdata_s;
        end
    end

    assign mem_ready = ready_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign lo_addr   = addr_q;
    assign hi_addr   = addr_q;
    assign lo_wdata  = lo_wdata_q;
    assign hi_wdata  = hi_wdata_q;
    assign lo_we_n   = lo_we_n_q;
    assign hi_we_n   = hi_we_n_q;

`ifdef MEMCTRL_ALIGN_ERR_EN
    logic align_err_q, align_err_d;

    // Misalignment flag accompanies the completion pulse
    always_comb begin
        align_err_d = ((state_q == ST_ACCESS) && (cnt_q == CNT_ZERO)) ? misalign_q : 1'b0;
    end

    // Alignment error register
    always_ff @(posedge clk) begin
        if (!reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Self-checking bench for lc3b_mem_ctrl: behavioural bank models plus an
// array-based reference memory; honours MEMCTRL_ALIGN_ERR_EN when defined.
module tb_lc3b_mem_ctrl;

    localparam int MEM_CYCLES = 4;
`ifdef MEMCTRL_ALIGN_ERR_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        mem_ready, busy;
    logic [15:0] rdata;
    logic [7:0]  lo_addr, hi_addr, lo_wdata, hi_wdata, lo_rdata, hi_rdata;
    logic        lo_we_n, hi_we_n;
`ifdef MEMCTRL_ALIGN_ERR_EN
    logic        align_err;
`endif

    logic [7:0]  lo_mem [256];
    logic [7:0]  hi_mem [256];
    logic [7:0]  ref_lo [256];
    logic [7:0]  ref_hi [256];
    bit          init_done = 1'b0;
    int          lo_wr_cnt = 0;
    int          hi_wr_cnt = 0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    lc3b_mem_ctrl #(.MEM_CYCLES(MEM_CYCLES), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_ready (mem_ready),
        .rdata     (rdata),
        .busy      (busy),
        .lo_addr   (lo_addr),
        .lo_wdata  (lo_wdata),
        .lo_we_n   (lo_we_n),
        .lo_rdata  (lo_rdata),
        .hi_addr   (hi_addr),
        .hi_wdata  (hi_wdata),
        .hi_we_n   (hi_we_n),
        .hi_rdata  (hi_rdata)
`ifdef MEMCTRL_ALIGN_ERR_EN
        ,
        .align_err (align_err)
`endif
    );

    always #5 clk = ~clk;

    // Byte banks: preload once, then write/read on each negedge
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) begin
                lo_mem[i] <= 8'(i * 7 + 3);
                hi_mem[i] <= 8'(i ^ 32'h5C);
            end
            lo_mem[0] <= 8'hD0;
            hi_mem[0] <= 8'hD2;
            init_done <= 1'b1;
        end else begin
            if (!lo_we_n) begin
                lo_mem[lo_addr] <= lo_wdata;
                lo_wr_cnt       <= lo_wr_cnt + 1;
            end
            if (!hi_we_n) begin
                hi_mem[hi_addr] <= hi_wdata;
                hi_wr_cnt       <= hi_wr_cnt + 1;
            end
        end
        lo_rdata <= lo_mem[lo_addr];
        hi_rdata <= hi_mem[hi_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: memory as two byte arrays indexed by addr[8:1]
    task automatic model(input logic we, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wd, output logic [15:0] rd, output logic ae,
                         output int lo_inc, output int hi_inc);
        int idx;
        bit mis;
        idx    = int'(addr[8:1]);
        mis    = ALIGN_EN && !byt && addr[0];
        ae     = mis;
        rd     = 16'h0000;
        lo_inc = 0;
        hi_inc = 0;
        if (!mis) begin
            if (we) begin
                if (!byt) begin
                    ref_lo[idx] = wd[7:0];
                    ref_hi[idx] = wd[15:8];
                    lo_inc = 1;
                    hi_inc = 1;
                end else if (addr[0]) begin
                    ref_hi[idx] = wd[7:0];
                    hi_inc = 1;
                end else begin
                    ref_lo[idx] = wd[7:0];
                    lo_inc = 1;
                end
            end else if (!byt) begin
                rd = {ref_hi[idx], ref_lo[idx]};
            end else begin
                rd = addr[0] ? {8'h00, ref_hi[idx]} : {8'h00, ref_lo[idx]};
            end
        end
    endtask

    // One access from IDLE; junk=1 wiggles the request bus while busy
    task automatic txn(input string tag, input logic we, input logic byt,
                       input logic [15:0] addr, input logic [15:0] wd, input bit junk,
                       output logic [15:0] rd_obs);
        logic [15:0] exp_rd;
        logic        exp_ae;
        int          lo_inc, hi_inc, lo0, hi0, n;
        model(we, byt, addr, wd, exp_rd, exp_ae, lo_inc, hi_inc);
        lo0 = lo_wr_cnt;
        hi0 = hi_wr_cnt;
        req_we = we; req_byte = byt; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!mem_ready && n < 40) begin
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'b1;
                req_byte  = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        rd_obs = rdata;
        check({tag, "_latency"}, 32'(n), 32'(MEM_CYCLES));
        if (!we || exp_ae) check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
`ifdef MEMCTRL_ALIGN_ERR_EN
        check({tag, "_align_err"}, 32'(align_err), 32'(exp_ae));
`endif
        @(posedge clk); #1;
        check({tag, "_lo_writes"}, 32'(lo_wr_cnt - lo0), 32'(lo_inc));
        check({tag, "_hi_writes"}, 32'(hi_wr_cnt - hi0), 32'(hi_inc));
        check({tag, "_ready_pulse"}, {30'd0, mem_ready, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] exp_w;
        int lo0, hi0, first, last, pulses, bad, n, mism;
        logic [7:0] keep_lo9, keep_hi9;

        for (int i = 0; i < 256; i++) begin
            ref_lo[i] = 8'(i * 7 + 3);
            ref_hi[i] = 8'(i ^ 32'h5C);
        end
        ref_lo[0] = 8'hD0;
        ref_hi[0] = 8'hD2;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", 32'(rdata),     32'd0);
        check("rst_we_n",  {30'd0, lo_we_n, hi_we_n}, 32'd3);
        check("rst_addr",  {16'd0, lo_addr, hi_addr}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        txn("w_beef", 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, rd);
        check("bank8_lo", 32'(lo_mem[8]), 32'h00EF);
        check("bank8_hi", 32'(hi_mem[8]), 32'h00BE);
        txn("r_beef", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, rd);
        check("r_beef_const", 32'(rd), 32'h0000BEEF);

        txn("wb_5a", 1'b1, 1'b1, 16'h0011, 16'h775A, 1'b0, rd);
        check("bank8_hi_5a", 32'(hi_mem[8]), 32'h005A);
        check("bank8_lo_keep", 32'(lo_mem[8]), 32'h00EF);
        txn("rb_hi", 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, rd);
        check("rb_hi_const", 32'(rd), 32'h0000005A);
        txn("rb_lo", 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, rd);
        check("rb_lo_const", 32'(rd), 32'h000000EF);

        txn("r_pre", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, rd);
        check("r_pre_const", 32'(rd), 32'h0000D2D0);
        txn("r_wrap", 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, rd);
        check("r_wrap_const", 32'(rd), 32'h0000D2D0);

        keep_lo9 = lo_mem[9];
        keep_hi9 = hi_mem[9];
        txn("w_odd", 1'b1, 1'b0, 16'h0013, 16'h1234, 1'b0, rd);
        if (ALIGN_EN) begin
            check("odd_lo9", 32'(lo_mem[9]), 32'(keep_lo9));
            check("odd_hi9", 32'(hi_mem[9]), 32'(keep_hi9));
        end else begin
            check("odd_lo9", 32'(lo_mem[9]), 32'h0034);
            check("odd_hi9", 32'(hi_mem[9]), 32'h0012);
        end

        // Reset for two edges in the middle of a write
        lo0 = lo_wr_cnt; hi0 = hi_wr_cnt;
        req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0030; req_wdata = 16'hA5A5;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("mid_rst_busy",  32'(busy),      32'd0);
            check("mid_rst_ready", 32'(mem_ready), 32'd0);
            check("mid_rst_we_n",  {30'd0, lo_we_n, hi_we_n}, 32'd3);
        end
        reset = 1'b1;
        repeat (MEM_CYCLES + 2) @(posedge clk);
        #1;
        check("mid_rst_writes", 32'(lo_wr_cnt - lo0 + hi_wr_cnt - hi0), 32'd0);
        check("mid_rst_bank", {16'd0, hi_mem[24], lo_mem[24]}, {16'd0, ref_hi[24], ref_lo[24]});

        // Continuous req_valid: one completion every MEM_CYCLES+2 cycles
        exp_w = {ref_hi[8], ref_lo[8]};
        req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        first = -1; last = -1; pulses = 0; bad = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                pulses++;
                if (first < 0) first = e;
                else if (e - last != MEM_CYCLES + 2) bad++;
                last = e;
                check("stream_rdata", 32'(rdata), 32'(exp_w));
            end
        end
        req_valid = 1'b0;
        check("stream_first",   32'(first),  32'(MEM_CYCLES + 1));
        check("stream_pulses",  32'(pulses), 32'd3);
        check("stream_spacing", 32'(bad),    32'd0);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("stream_drain", 32'(busy), 32'd0);

        for (int t = 0; t < 24; t++) begin
            txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), 1'b1, rd);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (lo_mem[i] !== ref_lo[i] || hi_mem[i] !== ref_hi[i]) mism++;
        end
        check("final_bank_image", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
